led_chain_rx: RTL and testbench

Oversampling receiver for the LED driver shift-chain interface (LAT/SDO/SCLK, TLC5955-style, NUM_SHIFT parallel lanes). It samples the chain lines in the spiClk domain, deserializes each lane MSB-first into a select bit plus 16-bit words, and reports word and latch events with framing checks. It sits on the consumer end of the chain: on the loopback/self-test path and in the simulation environment as the driver model that checks transmitter output.

---
 rtl/led_chain_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_led_chain_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_chain_rx.sv
// led_chain_rx: oversampling receiver for the LAT/SDO/SCLK LED driver shift chain.
// Optional macro LED_RX_CHECKSUM_EN adds a running XOR of lane-0 words reported per latch.
module led_chain_rx #(
  parameter int unsigned NUM_SHIFT = 8,
  parameter int unsigned WORDS     = 48
) (
  input  logic                            spiClk,
  input  logic                            nReset,
  input  logic                            enable,
  input  logic                            SCLK_in,
  input  logic [NUM_SHIFT-1:0]            SDO_in,
  input  logic                            LAT_in,
  output logic                            wordValid,
  output logic [$clog2(WORDS)-1:0]        wordIdx,
  output logic [16*NUM_SHIFT-1:0]         wordData,
  output logic [NUM_SHIFT-1:0]            selBit,
  output logic                            latchValid,
  output logic                            latchErr,
  output logic [$clog2(16*WORDS+2):0]     bitCount,
  output logic [15:0]                     checksum
);

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned SUB_W      = 4;
  localparam int unsigned SHIFT_BITS = 1 + WORD_W * WORDS;
  localparam int unsigned CNT_W      = $clog2(SHIFT_BITS + 1) + 1;
  localparam int unsigned IDX_W      = $clog2(WORDS);
  localparam int unsigned WCNT_W     = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DATA     = 2'd2,
    OVERFLOW = 2'd3
  } state_e;

  typedef logic [NUM_SHIFT-1:0][WORD_W-1:0] lanes_t;

  // Input synchronizers plus previous-value stage for edge detection
  logic                 sclk_meta_q, sclk_cur_q, sclk_prev_q;
  logic                 lat_meta_q, lat_cur_q, lat_prev_q;
  logic [NUM_SHIFT-1:0] sdo_meta_q, sdo_cur_q;
  logic                 sclk_rise_c, lat_rise_c;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d, bit_inc_c;
  logic [WCNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [SUB_W-1:0]     sub_cnt_q, sub_cnt_d;
  lanes_t               shift_q, shift_d;
  logic [NUM_SHIFT-1:0] sel_shadow_q, sel_shadow_d;

  logic                 word_valid_q, word_valid_d;
  logic [IDX_W-1:0]     word_idx_q, word_idx_d;
  lanes_t               word_data_q, word_data_d;
  logic [NUM_SHIFT-1:0] sel_bit_q, sel_bit_d;
  logic                 latch_valid_q, latch_valid_d;
  logic                 latch_err_q, latch_err_d;
  logic [CNT_W-1:0]     bit_count_q, bit_count_d;

`ifdef LED_RX_CHECKSUM_EN
  logic [WORD_W-1:0]    csum_q, csum_d;
  logic [WORD_W-1:0]    checksum_q, checksum_d;
`endif

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      sclk_meta_q <= 1'b0;
      sclk_cur_q  <= 1'b0;
      sclk_prev_q <= 1'b0;
      lat_meta_q  <= 1'b0;
      lat_cur_q   <= 1'b0;
      lat_prev_q  <= 1'b0;
      sdo_meta_q  <= '0;
      sdo_cur_q   <= '0;
    end else begin
      sclk_meta_q <= SCLK_in;
      sclk_cur_q  <= sclk_meta_q;
      sclk_prev_q <= sclk_cur_q;
      lat_meta_q  <= LAT_in;
      lat_cur_q   <= lat_meta_q;
      lat_prev_q  <= lat_cur_q;
      sdo_meta_q  <= SDO_in;
      sdo_cur_q   <= sdo_meta_q;
    end
  end

  assign sclk_rise_c = sclk_cur_q & ~sclk_prev_q;
  assign lat_rise_c  = lat_cur_q & ~lat_prev_q;
  assign bit_inc_c   = (bit_cnt_q == '1) ? bit_cnt_q : CNT_W'(bit_cnt_q + CNT_W'(1));

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      sub_cnt_q     <= '0;
      shift_q       <= '0;
      sel_shadow_q  <= '0;
      word_valid_q  <= 1'b0;
      word_idx_q    <= '0;
      word_data_q   <= '0;
      sel_bit_q     <= '0;
      latch_valid_q <= 1'b0;
      latch_err_q   <= 1'b0;
      bit_count_q   <= '0;
`ifdef LED_RX_CHECKSUM_EN
      csum_q        <= '0;
      checksum_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      sub_cnt_q     <= sub_cnt_d;
      shift_q       <= shift_d;
      sel_shadow_q  <= sel_shadow_d;
      word_valid_q  <= word_valid_d;
      word_idx_q    <= word_idx_d;
      word_data_q   <= word_data_d;
      sel_bit_q     <= sel_bit_d;
      latch_valid_q <= latch_valid_d;
      latch_err_q   <= latch_err_d;
      bit_count_q   <= bit_count_d;
`ifdef LED_RX_CHECKSUM_EN
      csum_q        <= csum_d;
      checksum_q    <= checksum_d;
`endif
    end
  end

  // Bit is shifted and counted before a coincident latch is evaluated
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    sub_cnt_d     = sub_cnt_q;
    shift_d       = shift_q;
    sel_shadow_d  = sel_shadow_q;
    word_valid_d  = 1'b0;
    word_idx_d    = word_idx_q;
    word_data_d   = word_data_q;
    sel_bit_d     = sel_bit_q;
    latch_valid_d = 1'b0;
    latch_err_d   = latch_err_q;
    bit_count_d   = bit_count_q;
`ifdef LED_RX_CHECKSUM_EN
    csum_d        = csum_q;
    checksum_d    = checksum_q;
`endif

    if (!enable) begin
      state_d      = IDLE;
      bit_cnt_d    = '0;
      word_cnt_d   = '0;
      sub_cnt_d    = '0;
      shift_d      = '0;
      sel_shadow_d = '0;
`ifdef LED_RX_CHECKSUM_EN
      csum_d       = '0;
`endif
    end else begin
      if (sclk_rise_c) begin
        case (state_q)
          IDLE: begin
            sel_shadow_d = sdo_cur_q;
            bit_cnt_d    = CNT_W'(1);
            word_cnt_d   = '0;
            sub_cnt_d    = '0;
            state_d      = DATA;
`ifdef LED_RX_CHECKSUM_EN
            csum_d       = '0;
`endif
          end
          DATA: begin
            bit_cnt_d = bit_inc_c;
            if (word_cnt_q == WCNT_W'(WORDS)) begin
              state_d = OVERFLOW;
            end else begin
              for (int k = 0; k < int'(NUM_SHIFT); k++) begin
                shift_d[k] = {shift_q[k][WORD_W-2:0], sdo_cur_q[k]};
              end
              sub_cnt_d = SUB_W'(sub_cnt_q + SUB_W'(1));
              if (sub_cnt_q == SUB_W'(WORD_W - 1)) begin
                word_valid_d = 1'b1;
                word_idx_d   = IDX_W'(word_cnt_q);
                word_data_d  = shift_d;
                word_cnt_d   = WCNT_W'(word_cnt_q + WCNT_W'(1));
`ifdef LED_RX_CHECKSUM_EN
                csum_d       = csum_q ^ shift_d[0];
`endif
              end
            end
          end
          OVERFLOW: bit_cnt_d = bit_inc_c;
          default:  state_d = IDLE;
        endcase
      end

      if (lat_rise_c) begin
        latch_valid_d = 1'b1;
        if (state_d == IDLE && bit_cnt_d == '0) begin
          latch_err_d = 1'b1;
          bit_count_d = '0;
        end else begin
          sel_bit_d   = sel_shadow_d;
          bit_count_d = bit_cnt_d;
          latch_err_d = (bit_cnt_d != CNT_W'(SHIFT_BITS));
`ifdef LED_RX_CHECKSUM_EN
          checksum_d  = csum_d;
`endif
        end
        state_d      = IDLE;
        bit_cnt_d    = '0;
        word_cnt_d   = '0;
        sub_cnt_d    = '0;
        shift_d      = '0;
        sel_shadow_d = '0;
`ifdef LED_RX_CHECKSUM_EN
        csum_d       = '0;
`endif
      end
    end
  end

  assign wordValid  = word_valid_q;
  assign wordIdx    = word_idx_q;
  assign wordData   = word_data_q;
  assign selBit     = sel_bit_q;
  assign latchValid = latch_valid_q;
  assign latchErr   = latch_err_q;
  assign bitCount   = bit_count_q;
`ifdef LED_RX_CHECKSUM_EN
  assign checksum   = checksum_q;
`else
  assign checksum   = '0;
`endif

endmodule

// File: tb/tb_led_chain_rx.sv
// tb_led_chain_rx: directed frames with a queue scoreboard checked by a decoupled monitor.
module tb_led_chain_rx;

  localparam int unsigned NUM_SHIFT = 8;
  localparam int unsigned WORDS     = 48;
  localparam int          NBITS     = 1 + 16 * int'(WORDS);
  localparam int unsigned IDX_W     = $clog2(WORDS);
  localparam int unsigned CNT_W     = $clog2(16 * WORDS + 2) + 1;
  localparam int unsigned DW        = 16 * NUM_SHIFT;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [DW-1:0]    data;
  } word_exp_t;

  typedef struct packed {
    logic                 err;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_SHIFT-1:0] sel;
    logic [15:0]          csum;
  } latch_exp_t;

  logic                 spiClk = 1'b0;
  logic                 nReset = 1'b0;
  logic                 enable = 1'b1;
  logic                 SCLK_in = 1'b0;
  logic [NUM_SHIFT-1:0] SDO_in = '0;
  logic                 LAT_in = 1'b0;
  logic                 wordValid;
  logic [IDX_W-1:0]     wordIdx;
  logic [DW-1:0]        wordData;
  logic [NUM_SHIFT-1:0] selBit;
  logic                 latchValid;
  logic                 latchErr;
  logic [CNT_W-1:0]     bitCount;
  logic [15:0]          checksum;

  int checks   = 0;
  int failures = 0;

  word_exp_t            exp_words[$];
  latch_exp_t           exp_latch[$];
  logic [NUM_SHIFT-1:0] last_sel;
  logic [15:0]          last_csum;

  led_chain_rx #(.NUM_SHIFT(NUM_SHIFT), .WORDS(WORDS)) dut (
    .spiClk     (spiClk),
    .nReset     (nReset),
    .enable     (enable),
    .SCLK_in    (SCLK_in),
    .SDO_in     (SDO_in),
    .LAT_in     (LAT_in),
    .wordValid  (wordValid),
    .wordIdx    (wordIdx),
    .wordData   (wordData),
    .selBit     (selBit),
    .latchValid (latchValid),
    .latchErr   (latchErr),
    .bitCount   (bitCount),
    .checksum   (checksum)
  );

  always #5 spiClk = ~spiClk;

  // Pattern 0: every lane sends A000+w; 1: lane/word mix; 2: lane 0 sends 1..48
  function automatic logic [15:0] word_of(input int pat, input int k, input int w);
    case (pat)
      0:       return 16'(16'hA000 + w);
      1:       return 16'(k * 16'h1111) ^ 16'(w * 16'h0101);
      default: return (k == 0) ? 16'(w + 1) : 16'(16'hC000 + k * 256 + w);
    endcase
  endfunction

  function automatic logic sel_of(input int pat, input int k);
    logic [7:0] s;
    case (pat)
      0:       s = 8'hAA;
      1:       s = 8'h5A;
      default: s = 8'h0F;
    endcase
    return s[k];
  endfunction

  function automatic logic [NUM_SHIFT-1:0] bits_at(input int pat, input int i);
    logic [NUM_SHIFT-1:0] v;
    logic [15:0]          wd;
    for (int k = 0; k < int'(NUM_SHIFT); k++) begin
      if (i == 0) begin
        v[k] = sel_of(pat, k);
      end else if (i >= NBITS) begin
        v[k] = ((i + k) % 3) == 0;
      end else begin
        wd   = word_of(pat, k, (i - 1) / 16);
        v[k] = wd[15 - ((i - 1) % 16)];
      end
    end
    return v;
  endfunction

  task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_wordValid"},  DW'(wordValid),  '0);
    check_val({tag, "_wordIdx"},    DW'(wordIdx),    '0);
    check_val({tag, "_wordData"},   wordData,        '0);
    check_val({tag, "_selBit"},     DW'(selBit),     '0);
    check_val({tag, "_latchValid"}, DW'(latchValid), '0);
    check_val({tag, "_latchErr"},   DW'(latchErr),   '0);
    check_val({tag, "_bitCount"},   DW'(bitCount),   '0);
    check_val({tag, "_checksum"},   DW'(checksum),   '0);
  endtask

  // SCLK low 3 cycles with data set up, then high 3 cycles
  task automatic drive_bit(input int pat, input int i, input bit with_lat);
    @(negedge spiClk);
    SCLK_in = 1'b0;
    SDO_in  = bits_at(pat, i);
    repeat (3) @(negedge spiClk);
    SCLK_in = 1'b1;
    if (with_lat) LAT_in = 1'b1;
    repeat (2) @(negedge spiClk);
  endtask

  task automatic pulse_lat();
    @(negedge spiClk);
    SCLK_in = 1'b0;
    repeat (3) @(negedge spiClk);
    LAT_in = 1'b1;
    repeat (3) @(negedge spiClk);
    LAT_in = 1'b0;
    repeat (3) @(negedge spiClk);
  endtask

  task automatic push_words(input int pat, input int nw, output logic [15:0] cs);
    word_exp_t we;
    cs = '0;
    for (int w = 0; w < nw; w++) begin
      we.idx = IDX_W'(w);
      for (int k = 0; k < int'(NUM_SHIFT); k++) we.data[16*k +: 16] = word_of(pat, k, w);
      exp_words.push_back(we);
      cs ^= word_of(pat, 0, w);
    end
  endtask

  task automatic run_frame(input int pat, input int nbits, input bit sim);
    latch_exp_t  le;
    int          nw;
    logic [15:0] cs;
    nw = (nbits - 1) / 16;
    if (nw > int'(WORDS)) nw = int'(WORDS);
    push_words(pat, nw, cs);
    le.err = (nbits != NBITS);
    le.cnt = CNT_W'(nbits);
    for (int k = 0; k < int'(NUM_SHIFT); k++) le.sel[k] = sel_of(pat, k);
`ifdef LED_RX_CHECKSUM_EN
    le.csum = cs;
`else
    le.csum = '0;
`endif
    exp_latch.push_back(le);
    last_sel  = le.sel;
    last_csum = le.csum;
    for (int i = 0; i < nbits; i++) drive_bit(pat, i, sim && (i == nbits - 1));
    if (sim) begin
      @(negedge spiClk);
      SCLK_in = 1'b0;
      LAT_in  = 1'b0;
    end else begin
      pulse_lat();
    end
    repeat (12) @(negedge spiClk);
  endtask

  // Monitor: pops expectations whenever the DUT pulses
  always @(negedge spiClk) begin
    word_exp_t  we;
    latch_exp_t le;
    if (wordValid) begin
      checks++;
      if (exp_words.size() == 0) begin
        failures++;
        $display("FAIL word_unexpected got idx=%0d exp=none", wordIdx);
      end else begin
        we = exp_words.pop_front();
        if (wordIdx !== we.idx || wordData !== we.data) begin
          failures++;
          $display("FAIL word idx got=%0d exp=%0d data got=%h exp=%h", wordIdx, we.idx, wordData, we.data);
        end
      end
    end
    if (latchValid) begin
      checks++;
      if (exp_latch.size() == 0) begin
        failures++;
        $display("FAIL latch_unexpected got cnt=%0d exp=none", bitCount);
      end else begin
        le = exp_latch.pop_front();
        if (latchErr !== le.err || bitCount !== le.cnt || selBit !== le.sel || checksum !== le.csum) begin
          failures++;
          $display("FAIL latch err got=%0b exp=%0b cnt got=%0d exp=%0d sel got=%h exp=%h csum got=%h exp=%h",
                   latchErr, le.err, bitCount, le.cnt, selBit, le.sel, checksum, le.csum);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    latch_exp_t  le;
    logic [15:0] cs;
    repeat (5) @(negedge spiClk);
    nReset = 1'b1;
    repeat (2) @(negedge spiClk);
    check_zero("reset");

    run_frame(0, NBITS, 1'b0);

    // Reset mid-stream after outputs hold non-zero values
    for (int i = 0; i < 10; i++) drive_bit(1, i, 1'b0);
    @(negedge spiClk);
    SCLK_in = 1'b0;
    nReset  = 1'b0;
    repeat (5) @(negedge spiClk);
    nReset = 1'b1;
    repeat (3) @(negedge spiClk);
    check_zero("midreset");

    run_frame(1, 500, 1'b0);
    run_frame(1, 800, 1'b0);

    // Enable drop after two words: frame discarded, no latch pulse while disabled
    push_words(1, 2, cs);
    for (int i = 0; i < 40; i++) drive_bit(1, i, 1'b0);
    @(negedge spiClk);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) drive_bit(2, i, 1'b0);
    pulse_lat();
    enable = 1'b1;
    repeat (12) @(negedge spiClk);

    run_frame(0, NBITS, 1'b1);
    run_frame(2, NBITS, 1'b0);

    // Latch with no bits: error flagged, select and checksum held
    le.err  = 1'b1;
    le.cnt  = '0;
    le.sel  = last_sel;
    le.csum = last_csum;
    exp_latch.push_back(le);
    pulse_lat();
    repeat (12) @(negedge spiClk);

    check_val("words_outstanding", DW'(exp_words.size()), '0);
    check_val("latches_outstanding", DW'(exp_latch.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
